// File: rtl/separador_pkg.sv
// Shared types and widths for the 16-bit to 8-bit word splitter.
package separador_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2
  } state_t;

endpackage

// File: rtl/separador.sv
// Splits each accepted 16-bit word into two bytes, emitted in MSB_FIRST order,
// flagging the second byte of every word with LAST.
module separador
  import separador_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] DATA16,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] OUT8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              LAST,
  output state_t            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and data stable until that edge.
  state_t            state_q, state_d;
  logic [WORD_W-1:0] held_q;
  logic [BYTE_W-1:0] first_byte, second_byte;
  logic              in_xfer;

  assign first_byte  = MSB_FIRST ? held_q[WORD_W-1:BYTE_W] : held_q[BYTE_W-1:0];
  assign second_byte = MSB_FIRST ? held_q[BYTE_W-1:0]      : held_q[WORD_W-1:BYTE_W];
  assign in_xfer     = in_valid & in_ready;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      if (in_xfer) held_q <= DATA16;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    LAST      = 1'b0;
    OUT8      = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BYTE1;
      end
      BYTE1: begin
        out_valid = 1'b1;
        OUT8      = first_byte;
        if (out_ready) state_d = BYTE2;
      end
      BYTE2: begin
        out_valid = 1'b1;
        LAST      = 1'b1;
        OUT8      = second_byte;
        // Accepting the next word while the last byte leaves avoids a bubble.
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? BYTE1 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_separador.sv
// Bench for separador: directed cases plus a random scoreboard run, driving an
// MSB-first and an LSB-first instance from the same stimulus.
module tb_separador;
  import separador_pkg::*;

  logic              clk;
  logic              reset;
  logic [WORD_W-1:0] DATA16;
  logic              in_valid;
  logic              out_ready;
  logic              in_ready, out_valid, LAST;
  logic [BYTE_W-1:0] OUT8;
  state_t            dbg_state;
  logic              in_ready_l, out_valid_l, last_l;
  logic [BYTE_W-1:0] out8_l;
  state_t            dbg_state_l;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [BYTE_W:0] exp_q[$];
  logic [BYTE_W:0] exp_l_q[$];

  separador #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .DATA16(DATA16), .in_valid(in_valid),
    .in_ready(in_ready), .OUT8(OUT8), .out_valid(out_valid),
    .out_ready(out_ready), .LAST(LAST), .dbg_state(dbg_state)
  );

  separador #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .DATA16(DATA16), .in_valid(in_valid),
    .in_ready(in_ready_l), .OUT8(out8_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .LAST(last_l), .dbg_state(dbg_state_l)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [7:0] b,
                           input logic lst, input logic ir);
    check({tag, "_valid"}, out_valid, ov);
    check({tag, "_byte"},  OUT8, b);
    check({tag, "_last"},  LAST, lst);
    check({tag, "_ready"}, in_ready, ir);
  endtask

  // Scoreboard: transfers are judged at the falling edge, where the inputs
  // already hold the values the next rising edge will sample.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_l_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) check("sb_unexpected_byte", {LAST, OUT8}, 9'h1ff);
        else check("sb_msb", {LAST, OUT8}, exp_q.pop_front());
      end
      if (out_valid_l && out_ready) begin
        if (exp_l_q.size() == 0) check("sb_unexpected_byte_l", {last_l, out8_l}, 9'h1ff);
        else check("sb_lsb", {last_l, out8_l}, exp_l_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, DATA16[15:8]});
        exp_q.push_back({1'b1, DATA16[7:0]});
      end
      if (in_valid && in_ready_l) begin
        exp_l_q.push_back({1'b0, DATA16[7:0]});
        exp_l_q.push_back({1'b1, DATA16[15:8]});
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    logic acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; DATA16 = '0;
    tick(); tick();
    reset = 1'b0;
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_state", dbg_state, IDLE);

    // Single word, both byte orders
    DATA16 = 16'hA55A; in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    check_out("single_b1", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_b1_l", {last_l, out8_l}, {1'b0, 8'h5A});
    tick();
    check_out("single_b2", 1'b1, 8'h5A, 1'b1, 1'b1);
    check("single_b2_l", {last_l, out8_l}, {1'b1, 8'hA5});
    tick();
    check_out("single_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // Back-to-back words
    DATA16 = 16'h1234; in_valid = 1'b1;
    tick(); DATA16 = 16'hBEEF;
    check_out("b2b_12", 1'b1, 8'h12, 1'b0, 1'b0);
    tick();
    check_out("b2b_34", 1'b1, 8'h34, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    check_out("b2b_be", 1'b1, 8'hBE, 1'b0, 1'b0);
    tick();
    check_out("b2b_ef", 1'b1, 8'hEF, 1'b1, 1'b1);
    tick();
    check("b2b_idle", dbg_state, IDLE);

    // Backpressure in BYTE1 with DATA16 churning
    DATA16 = 16'hC0DE; in_valid = 1'b1;
    tick(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DATA16 = 16'($urandom);
      tick();
      check_out("stall", 1'b1, 8'hC0, 1'b0, 1'b0);
      check("stall_state", dbg_state, BYTE1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_out("stall_de", 1'b1, 8'hDE, 1'b1, 1'b1);
    tick();
    check("stall_idle", dbg_state, IDLE);

    // Reset during BYTE2
    DATA16 = 16'h00FF; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    check_out("rst_pre", 1'b1, 8'hFF, 1'b1, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check_out("rst_post", 1'b0, 8'h00, 1'b0, 1'b1);
    DATA16 = 16'h1122; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check_out("rst_11", 1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    check_out("rst_22", 1'b1, 8'h22, 1'b1, 1'b1);
    tick();
    check("rst_idle", dbg_state, IDLE);

    // Random traffic: valid held until accepted, random consumer stalls
    pops = 0; sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        DATA16 = 16'($urandom);
      end else if (!in_valid) begin
        DATA16 = 16'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rand_words_sent", sent, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rand_drain_timeout", (cyc < 100), 1'b1);
    check("rand_byte_count", pops, 2000);
    check("rand_queue_empty", exp_q.size() + exp_l_q.size(), 0);
    check("rand_final_state", dbg_state, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
